// File: rtl/sreg_pkg.sv
// Shared mode encodings for the universal shift register and its benches.
package sreg_pkg;
  localparam logic [2:0] MODE_HOLD  = 3'b000;
  localparam logic [2:0] MODE_SHR   = 3'b001;
  localparam logic [2:0] MODE_SHL   = 3'b010;
  localparam logic [2:0] MODE_LOAD  = 3'b011;
  localparam logic [2:0] MODE_CLEAR = 3'b100;
  localparam logic [2:0] MODE_ROTR  = 3'b101;
  localparam logic [2:0] MODE_ROTL  = 3'b110;
endpackage

// File: rtl/sreg_frame_cnt.sv
// Modulo-WIDTH shift counter; wrap is a registered one-cycle pulse on the WIDTH-th inc.
// Latency 1 clk; no backpressure (inc is taken every cycle it is asserted).
module sreg_frame_cnt #(
  parameter int WIDTH = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic inc,
  input  logic clr,
  output logic wrap
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      cnt  <= '0;
      wrap <= 1'b0;
    end else if (inc) begin
      if (cnt == LAST) begin
        cnt  <= '0;
        wrap <= 1'b1;
      end else begin
        cnt  <= cnt + CW'(1);
        wrap <= 1'b0;
      end
    end else begin
      // Any cycle without a shift (hold, en=0) drops the pulse but keeps the count.
      wrap <= 1'b0;
    end
  end
endmodule

// File: rtl/univ_shift_reg.sv
// Universal shift register (hold/shr/shl/load/clear, optional rotates via UNIV_SREG_ROTATE_EN).
// Latency 1 clk; no backpressure, en=0 freezes all state.
module univ_shift_reg
  import sreg_pkg::*;
#(
  parameter int               WIDTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic             sin_r,
  input  logic             sin_l,
  input  logic [WIDTH-1:0] pin,
  output logic [WIDTH-1:0] q,
  output logic             sout_r,
  output logic             sout_l,
  output logic             frame_done
);
  logic [WIDTH-1:0] q_next;
  logic             inc;
  logic             clr;

  always_comb begin
    q_next = q;
    inc    = 1'b0;
    clr    = 1'b0;
    if (en) begin
      case (mode)
        MODE_SHR: begin
          q_next = {sin_r, q[WIDTH-1:1]};
          inc    = 1'b1;
        end
        MODE_SHL: begin
          q_next = {q[WIDTH-2:0], sin_l};
          inc    = 1'b1;
        end
        MODE_LOAD: begin
          q_next = pin;
          clr    = 1'b1;
        end
        MODE_CLEAR: begin
          q_next = RESET_VAL;
          clr    = 1'b1;
        end
`ifdef UNIV_SREG_ROTATE_EN
        MODE_ROTR: begin
          q_next = {q[0], q[WIDTH-1:1]};
          inc    = 1'b1;
        end
        MODE_ROTL: begin
          q_next = {q[WIDTH-2:0], q[WIDTH-1]};
          inc    = 1'b1;
        end
`endif
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) q <= RESET_VAL;
    else       q <= q_next;
  end

  assign sout_r = q[0];
  assign sout_l = q[WIDTH-1];

  sreg_frame_cnt #(.WIDTH(WIDTH)) u_frame_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (inc),
    .clr   (clr),
    .wrap  (frame_done)
  );
endmodule

// File: tb/tb_univ_shift_reg.sv
// Bench for univ_shift_reg: WIDTH=4/RESET_VAL=0 and WIDTH=8/RESET_VAL=0x0A instances vs an arithmetic model.
module tb_univ_shift_reg;
  import sreg_pkg::*;

  logic       clk = 1'b0;
  logic       reset, en, sin_r, sin_l;
  logic [2:0] mode;
  logic [3:0] pin4;
  logic [7:0] pin8;
  logic [3:0] q4;
  logic [7:0] q8;
  logic       sr4, sl4, fd4, sr8, sl8, fd8;

  int checks = 0;
  int errors = 0;
  bit check_en = 1'b0;

  int mq[2];
  int mn[2];
  int mfd[2];
  int mw[2]  = '{4, 8};
  int mrv[2] = '{0, 10};

  always #5 clk = ~clk;

  univ_shift_reg #(.WIDTH(4), .RESET_VAL(4'h0)) dut4 (
    .clk(clk), .reset(reset), .en(en), .mode(mode), .sin_r(sin_r), .sin_l(sin_l),
    .pin(pin4), .q(q4), .sout_r(sr4), .sout_l(sl4), .frame_done(fd4));

  univ_shift_reg #(.WIDTH(8), .RESET_VAL(8'h0A)) dut8 (
    .clk(clk), .reset(reset), .en(en), .mode(mode), .sin_r(sin_r), .sin_l(sin_l),
    .pin(pin8), .q(q8), .sout_r(sr8), .sout_l(sl8), .frame_done(fd8));

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endfunction

  // Literal expectation checked against both the DUT and the model.
  function automatic void lit(string name, logic [31:0] dut_val, int model_val, logic [31:0] exp);
    chk({name, "_dut"}, dut_val, exp);
    chk({name, "_model"}, model_val, exp);
  endfunction

  // Model: q as an integer, mn = shifts since the last frame boundary / load / clear / reset.
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      automatic int w    = mw[k];
      automatic int mask = (1 << w) - 1;
      automatic int p    = (k == 0) ? int'(pin4) : int'(pin8);
      automatic bit shifted = 1'b0;
      mfd[k] = 0;
      if (reset) begin
        mq[k] = mrv[k];
        mn[k] = 0;
      end else if (en) begin
        case (mode)
          MODE_SHR:   begin mq[k] = (mq[k] >> 1) | (int'(sin_r) << (w - 1)); shifted = 1'b1; end
          MODE_SHL:   begin mq[k] = ((mq[k] << 1) | int'(sin_l)) & mask; shifted = 1'b1; end
          MODE_LOAD:  begin mq[k] = p; mn[k] = 0; end
          MODE_CLEAR: begin mq[k] = mrv[k]; mn[k] = 0; end
`ifdef UNIV_SREG_ROTATE_EN
          MODE_ROTR:  begin mq[k] = (mq[k] >> 1) | ((mq[k] & 1) << (w - 1)); shifted = 1'b1; end
          MODE_ROTL:  begin mq[k] = ((mq[k] << 1) | (mq[k] >> (w - 1))) & mask; shifted = 1'b1; end
`endif
          default: ;
        endcase
        if (shifted) begin
          mn[k] = mn[k] + 1;
          if (mn[k] == w) begin
            mn[k]  = 0;
            mfd[k] = 1;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (check_en) begin
      chk("q4", q4, mq[0]);
      chk("sout_r4", sr4, mq[0] & 1);
      chk("sout_l4", sl4, (mq[0] >> 3) & 1);
      chk("frame_done4", fd4, mfd[0]);
      chk("q8", q8, mq[1]);
      chk("sout_r8", sr8, mq[1] & 1);
      chk("sout_l8", sl8, (mq[1] >> 7) & 1);
      chk("frame_done8", fd8, mfd[1]);
    end
  end

  task automatic step(input bit r, input bit e, input logic [2:0] m,
                      input bit s_r, input bit s_l, input logic [3:0] p4);
    reset = r;
    en    = e;
    mode  = m;
    sin_r = s_r;
    sin_l = s_l;
    pin4  = p4;
    pin8  = 8'($urandom);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int pulses4, pulses8;
    logic [3:0] held;
    logic [3:0] exp_rot [4];
    bit   [3:0] shr_in  = 4'b1100;
    bit   [3:0] ld_pat  = 4'b1011;
    logic [3:0] t1_q [4] = '{4'h0, 4'h0, 4'h8, 4'hC};

    reset = 1'b1; en = 1'b0; mode = MODE_HOLD; sin_r = 1'b0; sin_l = 1'b0;
    pin4 = '0; pin8 = '0;

    // Reset for two cycles
    step(1, 0, MODE_HOLD, 0, 0, 4'h0);
    step(1, 1, MODE_SHR, 1, 1, 4'hF);
    check_en = 1'b1;
    lit("rst_q4", q4, mq[0], 4'h0);
    lit("rst_q8", q8, mq[1], 8'h0A);
    lit("rst_fd4", fd4, mfd[0], 0);

    // SHR with sin_r = 0,0,1,1
    for (int i = 0; i < 4; i++) begin
      step(0, 1, MODE_SHR, shr_in[i], 0, 4'h0);
      lit("t1_q", q4, mq[0], t1_q[i]);
      lit("t1_fd", fd4, mfd[0], (i == 3) ? 1 : 0);
    end
    lit("t6_q8_after_shr", q8, mq[1], 8'hC0);
    lit("t6_fd8_half", fd8, mfd[1], 0);

    // LOAD 1011 then 4x SHL
    step(0, 1, MODE_LOAD, 0, 0, 4'b1011);
    for (int i = 0; i < 4; i++) begin
      lit("t2_sout_l", sl4, (mq[0] >> 3) & 1, ld_pat[3 - i]);
      step(0, 1, MODE_SHL, 0, 0, 4'h0);
      lit("t2_fd", fd4, mfd[0], (i == 3) ? 1 : 0);
    end
    lit("t2_q", q4, mq[0], 4'h0);

    // Reset mid-frame discards partial count
    step(0, 1, MODE_LOAD, 0, 0, 4'b1001);
    step(0, 1, MODE_SHR, 0, 0, 4'h0);
    step(0, 1, MODE_SHR, 0, 0, 4'h0);
    step(1, 1, MODE_SHR, 1, 1, 4'h0);
    lit("t3_rst_q4", q4, mq[0], 4'h0);
    lit("t3_rst_q8", q8, mq[1], 8'h0A);
    for (int i = 0; i < 4; i++) begin
      step(0, 1, MODE_SHR, 0, 0, 4'h0);
      lit("t3_fd", fd4, mfd[0], (i == 3) ? 1 : 0);
    end

    // en=0 mid-frame holds everything
    step(0, 1, MODE_SHR, 1, 0, 4'h0);
    step(0, 1, MODE_SHR, 1, 0, 4'h0);
    held = q4;
    lit("t4_q_pre", q4, mq[0], 4'hC);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, MODE_SHR, 1, 1, 4'h5);
      lit("t4_q_hold", q4, mq[0], held);
      lit("t4_fd_hold", fd4, mfd[0], 0);
    end
    step(0, 1, MODE_SHR, 1, 0, 4'h0);
    lit("t4_fd_3rd", fd4, mfd[0], 0);
    step(0, 1, MODE_SHR, 1, 0, 4'h0);
    lit("t4_q_end", q4, mq[0], 4'hF);
    lit("t4_fd_4th", fd4, mfd[0], 1);

    // CLEAR restores RESET_VAL; 8 shifts give one WIDTH=8 pulse, two WIDTH=4 pulses
    step(0, 1, MODE_CLEAR, 0, 0, 4'h0);
    lit("t6_clr_q8", q8, mq[1], 8'h0A);
    lit("t6_clr_q4", q4, mq[0], 4'h0);
    pulses4 = 0;
    pulses8 = 0;
    for (int i = 0; i < 8; i++) begin
      step(0, 1, MODE_SHL, 1, 1, 4'h0);
      pulses4 += int'(fd4);
      pulses8 += int'(fd8);
    end
    chk("t6_pulses8", pulses8, 1);
    chk("t6_pulses4", pulses4, 2);
    lit("t6_q8_end", q8, mq[1], 8'hFF);

    // ROTL
`ifdef UNIV_SREG_ROTATE_EN
    exp_rot = '{4'h2, 4'h4, 4'h8, 4'h1};
`else
    exp_rot = '{4'h1, 4'h1, 4'h1, 4'h1};
`endif
    step(0, 1, MODE_LOAD, 0, 0, 4'b0001);
    for (int i = 0; i < 4; i++) begin
      step(0, 1, MODE_ROTL, 1, 1, 4'h0);
      lit("t5_q", q4, mq[0], exp_rot[i]);
`ifdef UNIV_SREG_ROTATE_EN
      lit("t5_fd", fd4, mfd[0], (i == 3) ? 1 : 0);
`else
      lit("t5_fd", fd4, mfd[0], 0);
`endif
    end

    // Randomized traffic, checked every cycle by the compare process
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 39) == 0, $urandom_range(0, 7) != 0, 3'($urandom_range(0, 7)),
           1'($urandom), 1'($urandom), 4'($urandom));
    end

    @(negedge clk);
    check_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
